// File: rtl/accum_seq_pkg.sv
// Shared types for the accumulator sequencer: opcodes, FSM states, default width.
// No logic; types and constants only.
// Imported by the sequencer top.
package accum_seq_pkg;

  localparam int ACC_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LDA = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_OUT = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_EMIT  = 2'b11
  } state_e;

endpackage

// File: rtl/accum_alu.sv
// Add/subtract unit: a + b, or a + ~b + 1 when sub is set; reports carry and zero.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no handshake.
module accum_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // One extra bit of width so the carry-out (no-borrow for subtract) is kept.
  always_comb begin
    b_eff  = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    result = sum[WIDTH-1:0];
    carry  = sum[WIDTH];
    zero   = (sum[WIDTH-1:0] == '0);
  end

endmodule

// File: rtl/accum_sequencer.sv
// Control sequencer for the accumulator: turns LDA/ADD/SUB/OUT commands into load/oe strobes.
// Latency: LDA 2 cycles, ADD/SUB 3 cycles, OUT 3 cycles minimum (handshake cycle included).
// Backpressure: cmd_ready only in IDLE; EMIT holds out_valid/out_data until out_ready.
module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] bus,
  output logic             acc_load,
  output logic             acc_oe,
  input  logic [WIDTH-1:0] acc_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             flag_c,
  output logic             flag_z
);

  state_e           state_q, state_d;
  opcode_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             flag_c_q;
  logic             flag_z_q;

  logic [WIDTH-1:0] alu_a;
  logic             alu_sub;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;

  // LDA reuses the adder with a forced zero operand, so the written value and
  // its zero flag come from a single path for every opcode.
  always_comb begin
    alu_a   = (op_q == OP_LDA) ? '0 : a_q;
    alu_sub = (op_q == OP_SUB);
  end

  accum_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (alu_a),
    .b      (b_q),
    .sub    (alu_sub),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Next-state and strobe decode; load and oe live in disjoint states so they never overlap.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    acc_load  = 1'b0;
    acc_oe    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (opcode_e'(cmd_op) == OP_LDA) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        acc_oe  = 1'b1;
        state_d = (op_q == OP_OUT) ? ST_EMIT : ST_WRITE;
      end
      ST_WRITE: begin
        acc_load = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output muxing: bus and out_data are zero outside the cycles that qualify them.
  always_comb begin
    bus      = acc_load ? alu_result : '0;
    out_data = out_valid ? a_q : '0;
    flag_c   = flag_c_q;
    flag_z   = flag_z_q;
  end

  // State, command latch, accumulator snapshot and flags; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LDA;
      a_q      <= '0;
      b_q      <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && cmd_valid) begin
        op_q <= opcode_e'(cmd_op);
        b_q  <= cmd_data;
      end
      if (state_q == ST_READ) begin
        a_q <= acc_q;
      end
      if (state_q == ST_WRITE) begin
        flag_z_q <= alu_zero;
        if (op_q != OP_LDA) begin
          flag_c_q <= alu_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: plays the accumulator, drives commands, checks results.
// Latency under test: 2/3/3+stall cycles per LDA/ADD-SUB/OUT.
// Backpressure under test: out_ready stalls in EMIT and cmd_valid held across commands.
module tb_accum_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] bus;
  logic         acc_load;
  logic         acc_oe;
  logic [W-1:0] acc_q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flag_c;
  logic         flag_z;

  int n_cmp  = 0;
  int n_fail = 0;

  // Accumulator stand-in: no reset, loads from bus on acc_load.
  logic [W-1:0] acc = 8'hA5;
  int           load_cnt = 0;

  // Reference state, advanced by plain arithmetic per command.
  int ref_acc = 0;
  int ref_c   = 0;
  int ref_z   = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    int         dly;
    bit         hold;
    logic [7:0] res;
    bit         c;
    bit         z;
    int         cyc;
  } vec_t;

  vec_t tbl[12];

  accum_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .bus       (bus),
    .acc_load  (acc_load),
    .acc_oe    (acc_oe),
    .acc_q     (acc_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  always #5 clk = ~clk;

  assign acc_q = acc;

  // Accumulator register behaviour.
  always @(posedge clk) begin
    if (acc_load) begin
      acc      <= bus;
      load_cnt <= load_cnt + 1;
    end
  end

  // Strobe exclusivity and bus-idle-zero watch on every active strobe cycle.
  always @(negedge clk) begin
    if (!rst && (acc_load || acc_oe)) begin
      n_cmp++;
      if (acc_load && acc_oe) begin
        n_fail++;
        $display("FAIL strobe_overlap: acc_load=%0b acc_oe=%0b required not both 1", acc_load, acc_oe);
      end
      if (!acc_load) begin
        n_cmp++;
        if (bus !== '0) begin
          n_fail++;
          $display("FAIL bus_idle: got 0x%0h required 0x0", bus);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_acc_load"},  int'(acc_load),  0);
    chk({tag, "_acc_oe"},    int'(acc_oe),    0);
    chk({tag, "_bus"},       int'(bus),       0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"},  int'(out_data),  0);
    chk({tag, "_flag_c"},    int'(flag_c),    0);
    chk({tag, "_flag_z"},    int'(flag_z),    0);
  endtask

  // Reference: what each command should produce, from the arithmetic rules alone.
  task automatic ref_step(input logic [1:0] op, input logic [7:0] d, input int dly,
                          output int exp_res, output int exp_cyc, output int exp_loads);
    int dv;
    dv = int'(d);
    exp_loads = 1;
    case (op)
      2'd0: begin
        ref_acc = dv;
        ref_z   = (dv == 0) ? 1 : 0;
        exp_cyc = 2;
      end
      2'd1: begin
        ref_c   = (ref_acc + dv > 255) ? 1 : 0;
        ref_acc = (ref_acc + dv) % 256;
        ref_z   = (ref_acc == 0) ? 1 : 0;
        exp_cyc = 3;
      end
      2'd2: begin
        ref_c   = (ref_acc >= dv) ? 1 : 0;
        ref_acc = (ref_acc - dv + 256) % 256;
        ref_z   = (ref_acc == 0) ? 1 : 0;
        exp_cyc = 3;
      end
      default: begin
        exp_cyc   = 3 + dly;
        exp_loads = 0;
      end
    endcase
    exp_res = ref_acc;
  endtask

  // Issue one command from a negedge, follow it to the next IDLE, and report what was seen.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input int dly, input bit hold,
                         output logic [7:0] res, output int cyc, output int waits, output int loads);
    int         emit;
    int         l0;
    bit         done;
    logic [7:0] first_out;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    out_ready = 1'b0;
    waits     = 0;
    res       = '0;
    cyc       = 0;
    loads     = 0;
    first_out = '0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      chk("handshake_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    l0 = load_cnt;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    cyc  = 1;
    emit = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (cmd_ready) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (acc_load) res = bus;
        if (out_valid) begin
          if (emit == 0) first_out = out_data;
          else chk("emit_stable", int'(out_data), int'(first_out));
          emit++;
          res       = out_data;
          out_ready = (emit > dly);
        end
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
    if (!done) chk("complete_timeout", 0, 1);
    loads = load_cnt - l0;
  endtask

  initial begin
    logic [7:0] res;
    int         cyc, waits, loads;
    int         e_res, e_cyc, e_loads;
    int         l0;
    logic [1:0] rop;
    logic [7:0] rd;
    int         rdly;
    bit         rhold;

    tbl[0]  = '{2'd0, 8'h05, 0, 1'b0, 8'h05, 1'b0, 1'b0, 2};
    tbl[1]  = '{2'd1, 8'h03, 0, 1'b0, 8'h08, 1'b0, 1'b0, 3};
    tbl[2]  = '{2'd3, 8'h00, 0, 1'b0, 8'h08, 1'b0, 1'b0, 3};
    tbl[3]  = '{2'd1, 8'hFF, 0, 1'b0, 8'h07, 1'b1, 1'b0, 3};
    tbl[4]  = '{2'd0, 8'h07, 0, 1'b0, 8'h07, 1'b1, 1'b0, 2};
    tbl[5]  = '{2'd2, 8'h07, 0, 1'b0, 8'h00, 1'b1, 1'b1, 3};
    tbl[6]  = '{2'd2, 8'h01, 0, 1'b0, 8'hFF, 1'b0, 1'b0, 3};
    tbl[7]  = '{2'd3, 8'h00, 4, 1'b0, 8'hFF, 1'b0, 1'b0, 7};
    tbl[8]  = '{2'd0, 8'h10, 0, 1'b1, 8'h10, 1'b0, 1'b0, 2};
    tbl[9]  = '{2'd1, 8'h20, 0, 1'b1, 8'h30, 1'b0, 1'b0, 3};
    tbl[10] = '{2'd2, 8'h05, 0, 1'b1, 8'h2B, 1'b1, 1'b0, 3};
    tbl[11] = '{2'd3, 8'h00, 0, 1'b0, 8'h2B, 1'b1, 1'b0, 3};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      ref_step(tbl[i].op, tbl[i].d, tbl[i].dly, e_res, e_cyc, e_loads);
      run_cmd(tbl[i].op, tbl[i].d, tbl[i].dly, tbl[i].hold, res, cyc, waits, loads);
      chk($sformatf("tbl%0d_result", i), int'(res), int'(tbl[i].res));
      chk($sformatf("tbl%0d_flag_c", i), int'(flag_c), int'(tbl[i].c));
      chk($sformatf("tbl%0d_flag_z", i), int'(flag_z), int'(tbl[i].z));
      chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_waits", i), waits, 0);
      chk($sformatf("tbl%0d_loads", i), loads, (tbl[i].op == 2'd3) ? 0 : 1);
      if (tbl[i].op != 2'd3) chk($sformatf("tbl%0d_regA", i), int'(acc), int'(tbl[i].res));
    end
    cmd_valid = 1'b0;

    // Reset during the READ of an ADD: nothing is written, flags clear, regA survives.
    ref_step(2'd0, 8'h5A, 0, e_res, e_cyc, e_loads);
    run_cmd(2'd0, 8'h5A, 0, 1'b0, res, cyc, waits, loads);
    chk("rst_pre_regA", int'(acc), 8'h5A);
    cmd_op    = 2'd1;
    cmd_data  = 8'h11;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_in_read_oe", int'(acc_oe), 1);
    l0  = load_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst   = 1'b0;
    ref_c = 0;
    ref_z = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_load", load_cnt - l0, 0);
    chk("midrst_regA", int'(acc), 8'h5A);
    ref_step(2'd3, 8'h00, 0, e_res, e_cyc, e_loads);
    run_cmd(2'd3, 8'h00, 0, 1'b0, res, cyc, waits, loads);
    chk("midrst_out", int'(res), e_res);
    chk("midrst_out_cycles", cyc, e_cyc);

    // Random commands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom_range(0, 3));
      rd    = 8'($urandom);
      rdly  = $urandom_range(0, 3);
      rhold = 1'($urandom_range(0, 1));
      ref_step(rop, rd, rdly, e_res, e_cyc, e_loads);
      run_cmd(rop, rd, rdly, rhold, res, cyc, waits, loads);
      chk($sformatf("rnd%0d_result", i), int'(res), e_res);
      chk($sformatf("rnd%0d_flag_c", i), int'(flag_c), ref_c);
      chk($sformatf("rnd%0d_flag_z", i), int'(flag_z), ref_z);
      chk($sformatf("rnd%0d_cycles", i), cyc, e_cyc);
      chk($sformatf("rnd%0d_loads", i), loads, e_loads);
      chk($sformatf("rnd%0d_regA", i), int'(acc), ref_acc);
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
